// File: rtl/impulse_convolver.sv
`default_nettype none
// ============================================================================
//  Module      : impulse_convolver
//  Description : Stores a recorded impulse response in a coefficient RAM and
//                convolves each dry audio sample with it using a single,
//                time-multiplexed multiply-accumulate (one tap per clock).
//                Emits one saturated wet sample per audio trigger, or passes
//                the dry sample through when no impulse is ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module impulse_convolver #(
    parameter int TAPS       = 256,  // coefficient / history depth, power of 2
    parameter int ACC_W      = 40,   // signed accumulator width
    parameter int COEF_SHIFT = 15    // Q1.15 coefficient scaling
) (
    input  logic        audio_clk,
    input  logic        rst_in,
    input  logic        audio_trigger,
    input  logic [15:0] audio_in,
    input  logic        impulse_wr_en,
    input  logic [15:0] impulse_wr_addr,
    input  logic [15:0] impulse_wr_data,
    input  logic [15:0] impulse_length,
    input  logic        impulse_ready,
    output logic [15:0] audio_out,
    output logic        out_valid,
    output logic        busy,
    output logic        overrun
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_AW = $clog2(TAPS);   // RAM address width
    localparam int c_KW = c_AW + 1;       // tap count width, must hold TAPS itself

    localparam logic signed [ACC_W-1:0] c_SAT_MAX = {{(ACC_W-15){1'b0}}, {15{1'b1}}};
    localparam logic signed [ACC_W-1:0] c_SAT_MIN = {{(ACC_W-15){1'b1}}, {15{1'b0}}};

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_MAC   = 2'd2,
        S_ROUND = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    state_t                    r_state;
    state_t                    w_state_nxt;

    logic [c_AW-1:0]           r_clr_addr;
    logic [c_AW-1:0]           r_head;
    logic [c_KW-1:0]           r_k;
    logic [c_KW-1:0]           r_lc;
    logic                      r_rd_valid;
    logic signed [ACC_W-1:0]   r_acc;
    logic [15:0]               r_audio_out;
    logic                      r_out_valid;
    logic                      r_overrun;

    logic signed [15:0]        r_coef_mem [TAPS];
    logic signed [15:0]        r_hist_mem [TAPS];
    logic signed [15:0]        r_coef_q;
    logic signed [15:0]        r_hist_q;

    logic [c_KW-1:0]           w_lc;
    logic                      w_trig_idle;
    logic                      w_issue;
    logic [c_AW-1:0]           w_rd_addr_h;
    logic [c_AW-1:0]           w_rd_addr_x;
    logic                      w_coef_we;
    logic                      w_hist_we;
    logic [c_AW-1:0]           w_hist_waddr;
    logic signed [15:0]        w_hist_wdata;
    logic signed [31:0]        w_prod;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [ACC_W-1:0]   w_shifted;
    logic [15:0]               w_sat;

    // ------------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------------
    assign w_trig_idle = audio_trigger && (r_state == S_IDLE);

    // Issue one tap per MAC cycle until all latched taps have been read.
    assign w_issue     = (r_state == S_MAC) && (r_k < r_lc);

    // Tap k pairs h[k] with the sample k periods old: x[(head - k) mod TAPS].
    assign w_rd_addr_h = r_k[c_AW-1:0];
    assign w_rd_addr_x = r_head - r_k[c_AW-1:0];

    // Out-of-range coefficient addresses are dropped, not aliased.
    assign w_coef_we   = impulse_wr_en && (impulse_wr_addr < 16'(TAPS));

    // History has one write port: CLEAR zero-fill, or the new sample in IDLE.
    assign w_hist_we    = (r_state == S_CLEAR) || w_trig_idle;
    assign w_hist_waddr = (r_state == S_CLEAR) ? r_clr_addr : r_head;
    assign w_hist_wdata = (r_state == S_CLEAR) ? 16'sd0 : $signed(audio_in);

    // Clamp the requested impulse length to the RAM depth.
    always_comb begin
        w_lc = impulse_length[c_KW-1:0];
        if (impulse_length > 16'(TAPS)) begin
            w_lc = c_KW'(TAPS);
        end
    end

    // ------------------------------------------------------------------------
    // Datapath arithmetic
    // ------------------------------------------------------------------------
    assign w_prod     = r_coef_q * r_hist_q;
    assign w_prod_ext = {{(ACC_W-32){w_prod[31]}}, w_prod};
    assign w_shifted  = r_acc >>> COEF_SHIFT;

    // Saturate the scaled accumulator into the signed 16-bit output range.
    always_comb begin
        w_sat = w_shifted[15:0];
        if (w_shifted > c_SAT_MAX) begin
            w_sat = 16'h7FFF;
        end else if (w_shifted < c_SAT_MIN) begin
            w_sat = 16'h8000;
        end
    end

    // ------------------------------------------------------------------------
    // RAMs (single write port, registered read, contents not reset)
    // ------------------------------------------------------------------------
    // Coefficient RAM: recorder writes in any state, MAC reads h[k].
    always_ff @(posedge audio_clk) begin
        if (w_coef_we) begin
            r_coef_mem[impulse_wr_addr[c_AW-1:0]] <= $signed(impulse_wr_data);
        end
        r_coef_q <= r_coef_mem[w_rd_addr_h];
    end

    // History RAM: zero-fill / sample write, MAC reads the delayed sample.
    always_ff @(posedge audio_clk) begin
        if (w_hist_we) begin
            r_hist_mem[w_hist_waddr] <= w_hist_wdata;
        end
        r_hist_q <= r_hist_mem[w_rd_addr_x];
    end

    // ------------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------------
    // State register.
    always_ff @(posedge audio_clk or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CLEAR: begin
                if (r_clr_addr == c_AW'(TAPS - 1)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (audio_trigger && impulse_ready) begin
                    w_state_nxt = (w_lc == '0) ? S_ROUND : S_MAC;
                end
            end
            S_MAC: begin
                // All taps issued and the last product is being added now.
                if (!w_issue && r_rd_valid) begin
                    w_state_nxt = S_ROUND;
                end
            end
            S_ROUND: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_CLEAR;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    // Counters, accumulator and output registers, advanced per state.
    always_ff @(posedge audio_clk or negedge rst_in) begin
        if (!rst_in) begin
            r_clr_addr  <= '0;
            r_head      <= '0;
            r_k         <= '0;
            r_lc        <= '0;
            r_rd_valid  <= 1'b0;
            r_acc       <= '0;
            r_audio_out <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_CLEAR: begin
                    r_clr_addr <= r_clr_addr + 1'b1;
                end
                S_IDLE: begin
                    if (audio_trigger) begin
                        if (!impulse_ready) begin
                            r_audio_out <= audio_in;
                            r_out_valid <= 1'b1;
                            r_head      <= r_head + 1'b1;
                        end else begin
                            r_lc       <= w_lc;
                            r_k        <= '0;
                            r_acc      <= '0;
                            r_rd_valid <= 1'b0;
                        end
                    end
                end
                S_MAC: begin
                    if (w_issue) begin
                        r_k <= r_k + 1'b1;
                    end
                    r_rd_valid <= w_issue;
                    if (r_rd_valid) begin
                        r_acc <= r_acc + w_prod_ext;
                    end
                end
                S_ROUND: begin
                    r_audio_out <= w_sat;
                    r_out_valid <= 1'b1;
                    r_head      <= r_head + 1'b1;
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Sticky flag: a trigger landed while a computation was still running.
    always_ff @(posedge audio_clk or negedge rst_in) begin
        if (!rst_in) begin
            r_overrun <= 1'b0;
        end else if (audio_trigger && ((r_state == S_MAC) || (r_state == S_ROUND))) begin
            r_overrun <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign audio_out = r_audio_out;
    assign out_valid = r_out_valid;
    assign busy      = (r_state != S_IDLE);
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_impulse_convolver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_impulse_convolver
//  Description : Directed + randomized bench for impulse_convolver with a
//                sum-of-products reference model of the convolution.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_impulse_convolver;

    localparam int TAPS = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trig = 1'b0;
    logic [15:0] ain = '0;
    logic        wr_en = 1'b0;
    logic [15:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [15:0] len = '0;
    logic        ready = 1'b0;
    logic [15:0] aout;
    logic        ovalid;
    logic        busy;
    logic        overrun;

    impulse_convolver #(.TAPS(TAPS), .ACC_W(40), .COEF_SHIFT(15)) dut (
        .audio_clk       (clk),
        .rst_in          (rst_n),
        .audio_trigger   (trig),
        .audio_in        (ain),
        .impulse_wr_en   (wr_en),
        .impulse_wr_addr (wr_addr),
        .impulse_wr_data (wr_data),
        .impulse_length  (len),
        .impulse_ready   (ready),
        .audio_out       (aout),
        .out_valid       (ovalid),
        .busy            (busy),
        .overrun         (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Every out_valid pulse is logged with its cycle and value.
    int ev_cyc[$];
    int ev_val[$];
    always @(negedge clk) begin
        if (ovalid === 1'b1) begin
            ev_cyc.push_back(cyc);
            ev_val.push_back(int'($signed(aout)));
        end
    end

    // Reference model state: coefficients and the sample history since CLEAR.
    int m_coef[TAPS];
    int m_hist[TAPS];
    int m_head = 0;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int s16(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    // y[n] = sat( (sum_{k<Lc} h[k]*x[n-k]) >>> 15 ), history zero before CLEAR end.
    function automatic int model_sample(input int x, input bit rdy, input int lc);
        longint acc = 0;
        longint s;
        int y;
        m_hist[m_head] = x;
        if (!rdy) begin
            y = x;
        end else begin
            for (int k = 0; k < lc; k++) begin
                acc += longint'(m_coef[k]) * longint'(m_hist[(m_head - k + TAPS) % TAPS]);
            end
            s = acc >>> 15;
            if (s > 32767)       y = 32767;
            else if (s < -32768) y = -32768;
            else                 y = int'(s);
        end
        m_head = (m_head + 1) % TAPS;
        return y;
    endfunction

    task automatic wr_coef(input int a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = 16'(a); wr_data = d;
        tick();
        wr_en = 1'b0;
        if (a < TAPS) m_coef[a] = s16(d);
    endtask

    // Wait (bounded) for one output event and check its latency and value.
    task automatic expect_event(input string tag, input int c0, input int lat, input int y);
        int w = 0;
        while (ev_cyc.size() == 0 && w < 700) begin
            tick();
            w++;
        end
        check({tag, " pulse_count"}, ev_cyc.size(), 1);
        if (ev_cyc.size() != 0) begin
            check({tag, " latency"}, ev_cyc[0] - c0, lat);
            check({tag, " value"}, ev_val[0], y);
            void'(ev_cyc.pop_front());
            void'(ev_val.pop_front());
        end
        tick();
        tick();
        check({tag, " single_pulse"}, ev_cyc.size(), 0);
        ev_cyc.delete();
        ev_val.delete();
    endtask

    // One sample through an idle DUT; ready/length are scrambled afterwards
    // to confirm they are latched at the trigger.
    task automatic send(input string tag, input int x, input bit rdy, input logic [15:0] l);
        int lc, lat, y, c0;
        lc  = (int'(l) > TAPS) ? TAPS : int'(l);
        lat = !rdy ? 1 : ((lc == 0) ? 2 : lc + 3);
        y   = model_sample(x, rdy, lc);
        ready = rdy; len = l; ain = 16'(x); trig = 1'b1;
        c0 = cyc;
        tick();
        trig = 1'b0;
        len = 16'($urandom);
        if (rdy) ready = 1'($urandom);
        expect_event(tag, c0, lat, y);
    endtask

    task automatic do_reset(input bit trig_in_clear);
        int cr;
        int i;
        rst_n = 1'b0;
        trig = 1'b0;
        tick();
        check("rst busy", busy, 1);
        check("rst out_valid", ovalid, 0);
        check("rst overrun", overrun, 0);
        check("rst audio_out", aout, 0);
        tick();
        rst_n = 1'b1;
        cr = cyc;
        for (int k = 0; k < TAPS; k++) m_hist[k] = 0;
        m_head = 0;
        ready = 1'b1; len = 16'd4; ain = 16'h5555;
        i = 0;
        while (i < 1000) begin
            trig = trig_in_clear && (i >= 5) && (i < 8);
            @(negedge clk);
            if (busy === 1'b0) break;
            tick();
            i++;
        end
        trig = 1'b0;
        check("clear cycles", cyc - cr, TAPS);
        tick();
        check("clear no out_valid", ev_cyc.size(), 0);
        check("clear overrun", overrun, 0);
        ev_cyc.delete();
        ev_val.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, y, x;
        for (int k = 0; k < TAPS; k++) begin
            m_coef[k] = 0;
            m_hist[k] = 0;
        end
        tick();
        // Reset and CLEAR, with triggers dropped during CLEAR.
        do_reset(1'b1);
        for (int a = 0; a < TAPS; a++) wr_coef(a, 16'h0000);

        // Bypass.
        send("bypass", s16(16'h1234), 1'b0, 16'd1);

        // Single tap.
        wr_coef(0, 16'h7FFF);
        send("h0_7fff", 1000, 1'b1, 16'd1);
        wr_coef(0, 16'h4000);
        send("h0_4000", 1000, 1'b1, 16'd1);
        wr_coef(TAPS, 16'h7FFF);          // out of range: must not hit h[0]
        send("wr_oob", 1000, 1'b1, 16'd1);

        // Three taps on a clean history; coefficients survive reset.
        do_reset(1'b0);
        wr_coef(1, 16'h4000);
        wr_coef(2, 16'h4000);
        send("tap3_a", 8000, 1'b1, 16'd3);
        send("tap3_b", 0, 1'b1, 16'd3);
        send("tap3_c", 0, 1'b1, 16'd3);
        send("tap3_d", 0, 1'b1, 16'd3);
        send("len0", 12345, 1'b1, 16'd0);

        // Saturation both ways.
        wr_coef(0, 16'h7FFF);
        wr_coef(1, 16'h7FFF);
        send("sat_p1", 30000, 1'b1, 16'd2);
        send("sat_p2", 30000, 1'b1, 16'd2);
        send("sat_n1", -30000, 1'b1, 16'd2);
        send("sat_n2", -30000, 1'b1, 16'd2);

        // Randomized coefficients, lengths, samples and bypass mix.
        for (int it = 0; it < 40; it++) begin
            wr_coef($urandom_range(0, 19), 16'($urandom));
            x = s16(16'($urandom));
            send("rand", x, ($urandom_range(0, 4) != 0), 16'($urandom_range(0, 20)));
        end

        // Full-length impulse with triggers every 100 cycles.
        for (int a = 0; a < TAPS; a++) wr_coef(a, 16'($urandom));
        x = s16(16'($urandom));
        y = model_sample(x, 1'b1, TAPS);
        ready = 1'b1; len = 16'(TAPS); ain = 16'(x); trig = 1'b1;
        c0 = cyc;
        tick();
        trig = 1'b0;
        repeat (49) tick();
        check("ovr before drop", overrun, 0);
        repeat (50) tick();
        ain = 16'($urandom); trig = 1'b1;
        tick();
        trig = 1'b0;
        check("ovr after drop", overrun, 1);
        repeat (99) tick();
        ain = 16'($urandom); trig = 1'b1;
        tick();
        trig = 1'b0;
        expect_event("full_len", c0, TAPS + 3, y);
        check("ovr sticky", overrun, 1);

        // Oversized length clamps to TAPS.
        send("clamp", s16(16'($urandom)), 1'b1, 16'(70000));

        // Reset in the middle of MAC: result discarded, CLEAR re-entered.
        ready = 1'b1; len = 16'(TAPS); ain = 16'h0100; trig = 1'b1;
        tick();
        trig = 1'b0;
        repeat (50) tick();
        check("mid busy", busy, 1);
        do_reset(1'b0);
        repeat (TAPS + 10) tick();
        check("mid discarded", ev_cyc.size(), 0);
        send("post_reset", s16(16'($urandom)), 1'b1, 16'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
